pic_priority_scheduler: RTL and testbench
=========================================

// Module: pic_priority_scheduler
// PURPOSE
// - Clocked interrupt scheduler of the 8259A PIC: owns IRR, ISR and rotating priority, decides INT, picks the IR level served per INTA cycle.
// - Sits between IR pins / control logic (ICW/OCW fields, IMR) and the INTA ack sequencer.
// - Sequences one request per ack: IRR -> ISR on ACK1, vector on ACK2, ISR release on EOI/AEOI.
// PARAMETERS
// - NUM_IR   8  IR lines; fixed at 8, 3-bit level encoding.
// - RST_LOWP 7  lowest-priority level after reset (IR0 highest).
// PORTS
// - clk       in   1  single clock; all state on rising edge.
// - reset     in   1  synchronous, active-high.
// - IR        in   8  raw request lines, synchronous to clk.
// - IMR       in   8  mask; 1 = masked.
// - LTIM      in   1  1 level-, 0 edge-triggered.
// - AEOI      in   1  automatic EOI at end of ACK2.
// - SFNM      in   1  special fully nested: equal-level request may interrupt.
// - ocw2_wr   in   1  one-cycle strobe, ocw2 valid.
// - ocw2      in   8  {R,SL,EOI,0,0,L2,L1,L0}.
// - ack1      in   1  one-cycle strobe, first INTA falling edge.
// - ack2      in   1  one-cycle strobe, second INTA falling edge.
// - INT       out  1  interrupt request to CPU.
// - INT_VEC   out  3  level being served; valid from ACK1 until next ACK1.
// - vec_valid out  1  one-cycle pulse after ack2; INT_VEC = vector LSBs.
// - IRR_o     out  8  interrupt request register.
// - ISR_o     out  8  in-service register.
// BEHAVIOUR
// - Reset: IRR=ISR=0, INT=0, INT_VEC=0, vec_valid=0, lowp=RST_LOWP, rot_aeoi=0, FSM=IDLE. Reset mid-ACK aborts the cycle, no ISR change.
// - IRR edge mode: bit set on 0->1 of IR (prev IR registered, prev resets to 0), held until served or IR drops. Level mode: IRR = IR each cycle.
// - Priority: level (lowp+1) mod 8 highest, wraps to lowp. pend = IRR & ~IMR.
// - INT = 1 when highest pend level outranks highest ISR level (equal also wins if SFNM); registered, 1-cycle latency from IRR.
// - FSM IDLE -> ACK1_W on ack1; ACK1_W -> IDLE on ack2 (vec_valid=1 next cycle). ack2 in IDLE ignored. ack1 in ACK1_W restarts the cycle.
// - On ack1: winner = highest pend level (sampled this cycle); ISR[winner]=1, IRR[winner]=0, INT=0 until re-evaluated. No pend: INT_VEC=7, ISR unchanged (spurious IR7).
// - On ack2: if AEOI, clear ISR[INT_VEC]; if also rot_aeoi, lowp=INT_VEC.
// - OCW2 on ocw2_wr, by {R,SL,EOI}: 001 non-specific EOI (clear highest ISR bit); 011 specific EOI (clear ISR[L]); 101 rotate+NS-EOI (clear, lowp=that level); 111 rotate+S-EOI (clear ISR[L], lowp=L); 110 set priority (lowp=L); 100 rot_aeoi=1; 000 rot_aeoi=0; 010 no-op. NS-EOI with ISR=0: no change.
// - Simultaneous: ocw2 EOI and ack1 same cycle: EOI first, then ack1 arbitrates on updated ISR. ack1 with IR edge same cycle: new edge not eligible. IMR change takes effect on next INT evaluation.
// CONFIGURATION
// - Macro PIC_SPECIAL_MASK_EN: adds inputs smm_wr (1), smm (2, OCW3 ESMM/SMM). 11 sets, 10 clears special mask mode. In SMM: INT ignores ISR levels; pend also excludes ISR bits, masked ISR bits do not block lower levels.
// - Without macro: ports absent, SMM hard 0, fully nested behaviour only.
// TESTING
// - Edge mode, IMR=0, pulse IR3 -> INT=1 after 2 clk; ack1 -> ISR=08, IRR=00; ack2 -> vec_valid, INT_VEC=3.
// - IR2 and IR5 together, lowp=7 -> serves 2 first; OCW2=0x20 -> ISR=00, INT reasserts, second ack serves 5.
// - OCW2=0xC4 (lowp=4), IR3 and IR6 -> IR6 served first (5 highest).
// - AEOI=1, rot_aeoi set (OCW2=0x80), serve IR1 -> ISR=00 after ack2, lowp=1.
// - ack1 with IMR=FF and IR pending -> INT_VEC=7, ISR=00; reset between ack1 and ack2 -> all outputs 0, ack2 ignored.
// - PIC_SPECIAL_MASK_EN: ISR=04 masked, smm=11, IR6 -> INT=1; without SMM -> INT=0.

Source files
------------

// File: rtl/pic_priority_scheduler.sv
// 8259A interrupt scheduler: IRR/ISR bookkeeping, rotating priority, INT decision and INTA sequencing.
// Optional special mask mode (OCW3 ESMM/SMM) is compiled in with `define PIC_SPECIAL_MASK_EN.
module pic_priority_scheduler #(
    parameter int         NUM_IR   = 8,
    parameter logic [2:0] RST_LOWP = 3'd7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] IR,
    input  logic [NUM_IR-1:0] IMR,
    input  logic              LTIM,
    input  logic              AEOI,
    input  logic              SFNM,
    input  logic              ocw2_wr,
    input  logic [7:0]        ocw2,
    input  logic              ack1,
    input  logic              ack2,
`ifdef PIC_SPECIAL_MASK_EN
    input  logic              smm_wr,
    input  logic [1:0]        smm,
`endif
    output logic              INT,
    output logic [2:0]        INT_VEC,
    output logic              vec_valid,
    output logic [NUM_IR-1:0] IRR_o,
    output logic [NUM_IR-1:0] ISR_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACK1_W = 1'b1;

    logic [NUM_IR-1:0] irr, isr, prev_ir;
    logic [2:0]        lowp, int_vec;
    logic              rot_aeoi, int_r, vec_valid_r, smm_mode;
    logic [0:0]        state;

    logic [NUM_IR-1:0] irr_n, isr_n, isr_eoi, win_mask, pend_ack, pend_int;
    logic [2:0]        lowp_n, vec_n, isr_top, ack_lvl, pend_lvl;
    logic              rot_n, int_n, vv_n, isr_found, ack_found, pend_found, ocw2_hit;
    logic [0:0]        state_n;

    // Returns {found, level} of the highest-priority set bit; level lp+1 ranks first.
    function automatic logic [3:0] find_highest(input logic [NUM_IR-1:0] m, input logic [2:0] lp);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'b0;
        for (int i = NUM_IR; i >= 1; i--) begin
            lvl = lp + 3'(i);
            if (m[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

`ifdef PIC_SPECIAL_MASK_EN
    always_ff @(posedge clk) begin
        if (reset)
            smm_mode <= 1'b0;
        else if (smm_wr && smm[1])
            smm_mode <= smm[0];
    end
`else
    assign smm_mode = 1'b0;
`endif

    always_comb begin
        isr_eoi  = isr;
        lowp_n   = lowp;
        rot_n    = rot_aeoi;
        {isr_found, isr_top} = find_highest(isr, lowp);

        // Bits 4:3 distinguish OCW2 from OCW3/ICW1 writes sharing the same address.
        ocw2_hit = ocw2_wr && (ocw2[4:3] == 2'b00);
        if (ocw2_hit) begin
            case (ocw2[7:5])
                3'b001: if (isr_found) isr_eoi[isr_top] = 1'b0;
                3'b011: isr_eoi[ocw2[2:0]] = 1'b0;
                3'b101: if (isr_found) begin
                            isr_eoi[isr_top] = 1'b0;
                            lowp_n = isr_top;
                        end
                3'b111: begin
                            isr_eoi[ocw2[2:0]] = 1'b0;
                            lowp_n = ocw2[2:0];
                        end
                3'b110: lowp_n = ocw2[2:0];
                3'b100: rot_n = 1'b1;
                3'b000: rot_n = 1'b0;
                default: ;
            endcase
        end

        // ack1 arbitrates after any same-cycle EOI/rotation has been applied.
        pend_ack = irr & ~IMR & (smm_mode ? ~isr_eoi : {NUM_IR{1'b1}});
        {ack_found, ack_lvl} = find_highest(pend_ack, lowp_n);

        isr_n    = isr_eoi;
        win_mask = '0;
        vec_n    = int_vec;
        state_n  = state;
        vv_n     = 1'b0;
        if (ack1) begin
            state_n = ACK1_W;
            if (ack_found) begin
                isr_n[ack_lvl]    = 1'b1;
                win_mask[ack_lvl] = 1'b1;
                vec_n             = ack_lvl;
            end else begin
                vec_n = 3'd7;
            end
        end else if (ack2 && state == ACK1_W) begin
            state_n = IDLE;
            vv_n    = 1'b1;
            if (AEOI) begin
                isr_n[int_vec] = 1'b0;
                if (rot_aeoi) lowp_n = int_vec;
            end
        end

        if (LTIM)
            irr_n = IR & ~win_mask;
        else
            irr_n = (irr | (IR & ~prev_ir)) & IR & ~win_mask;

        pend_int = irr & ~IMR & (smm_mode ? ~isr : {NUM_IR{1'b1}});
        {pend_found, pend_lvl} = find_highest(pend_int, lowp);
        int_n = pend_found &&
                (smm_mode || !isr_found ||
                 (rank_of(pend_lvl, lowp) < rank_of(isr_top, lowp)) ||
                 (SFNM && pend_lvl == isr_top));
        if (ack1) int_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irr         <= '0;
            isr         <= '0;
            prev_ir     <= '0;
            lowp        <= RST_LOWP;
            rot_aeoi    <= 1'b0;
            state       <= IDLE;
            int_r       <= 1'b0;
            int_vec     <= 3'd0;
            vec_valid_r <= 1'b0;
        end else begin
            irr         <= irr_n;
            isr         <= isr_n;
            prev_ir     <= IR;
            lowp        <= lowp_n;
            rot_aeoi    <= rot_n;
            state       <= state_n;
            int_r       <= int_n;
            int_vec     <= vec_n;
            vec_valid_r <= vv_n;
        end
    end

    assign INT       = int_r;
    assign INT_VEC   = int_vec;
    assign vec_valid = vec_valid_r;
    assign IRR_o     = irr;
    assign ISR_o     = isr;

endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Directed bench for pic_priority_scheduler: hand-computed IRR/ISR/INT/vector values per step.
module tb_pic_priority_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR, IMR, ocw2;
    logic       LTIM, AEOI, SFNM, ocw2_wr, ack1, ack2;
    logic       INT, vec_valid;
    logic [2:0] INT_VEC;
    logic [7:0] IRR_o, ISR_o;
`ifdef PIC_SPECIAL_MASK_EN
    logic       smm_wr;
    logic [1:0] smm;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pic_priority_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .IR        (IR),
        .IMR       (IMR),
        .LTIM      (LTIM),
        .AEOI      (AEOI),
        .SFNM      (SFNM),
        .ocw2_wr   (ocw2_wr),
        .ocw2      (ocw2),
        .ack1      (ack1),
        .ack2      (ack2),
`ifdef PIC_SPECIAL_MASK_EN
        .smm_wr    (smm_wr),
        .smm       (smm),
`endif
        .INT       (INT),
        .INT_VEC   (INT_VEC),
        .vec_valid (vec_valid),
        .IRR_o     (IRR_o),
        .ISR_o     (ISR_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe of ack1/ack2/ocw2_wr, then back to idle.
    task automatic applyStimulus(input logic a1, input logic a2, input logic wr, input logic [7:0] oc);
        ack1    = a1;
        ack2    = a2;
        ocw2_wr = wr;
        ocw2    = oc;
        tick();
        ack1    = 1'b0;
        ack2    = 1'b0;
        ocw2_wr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; IR = '0; IMR = '0; ocw2 = '0;
        LTIM = 1'b0; AEOI = 1'b0; SFNM = 1'b0; ocw2_wr = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
`ifdef PIC_SPECIAL_MASK_EN
        smm_wr = 1'b0; smm = 2'b00;
`endif
        tick(); tick();
        checkOutput("reset_INT", {7'd0, INT}, 8'h00);
        checkOutput("reset_INT_VEC", {5'd0, INT_VEC}, 8'h00);
        checkOutput("reset_vec_valid", {7'd0, vec_valid}, 8'h00);
        checkOutput("reset_IRR", IRR_o, 8'h00);
        checkOutput("reset_ISR", ISR_o, 8'h00);
        reset = 1'b0;

        // IR3 edge: IRR after 1 clock, INT after 2
        IR = 8'h08;
        tick();
        checkOutput("ir3_IRR", IRR_o, 8'h08);
        checkOutput("ir3_INT_early", {7'd0, INT}, 8'h00);
        tick();
        checkOutput("ir3_INT", {7'd0, INT}, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("ir3_ack1_ISR", ISR_o, 8'h08);
        checkOutput("ir3_ack1_IRR", IRR_o, 8'h00);
        checkOutput("ir3_ack1_INT", {7'd0, INT}, 8'h00);
        checkOutput("ir3_ack1_VEC", {5'd0, INT_VEC}, 8'h03);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("ir3_vec_valid", {7'd0, vec_valid}, 8'h01);
        checkOutput("ir3_ack2_VEC", {5'd0, INT_VEC}, 8'h03);
        tick();
        checkOutput("ir3_vec_valid_drop", {7'd0, vec_valid}, 8'h00);
        IR = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h63);
        checkOutput("specific_eoi_ISR", ISR_o, 8'h00);

        // IR2 and IR5 together under default priority
        IR = 8'h24;
        tick(); tick();
        checkOutput("ir25_INT", {7'd0, INT}, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("ir25_first_VEC", {5'd0, INT_VEC}, 8'h02);
        checkOutput("ir25_first_ISR", ISR_o, 8'h04);
        checkOutput("ir25_first_IRR", IRR_o, 8'h20);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("ir25_nested_INT", {7'd0, INT}, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        checkOutput("ir25_nseoi_ISR", ISR_o, 8'h00);
        tick();
        checkOutput("ir25_reassert_INT", {7'd0, INT}, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("ir25_second_VEC", {5'd0, INT_VEC}, 8'h05);
        checkOutput("ir25_second_ISR", ISR_o, 8'h20);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        IR = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        checkOutput("ir25_final_ISR", ISR_o, 8'h00);

        // Set priority lowp=4: IR5 highest, so IR6 beats IR3
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC4);
        IR = 8'h48;
        tick(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rot_VEC", {5'd0, INT_VEC}, 8'h06);
        checkOutput("rot_ISR", ISR_o, 8'h40);
        checkOutput("rot_IRR", IRR_o, 8'h08);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        IR = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        checkOutput("rot_eoi_ISR", ISR_o, 8'h00);
        checkOutput("rot_drop_IRR", IRR_o, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC7);

        // AEOI with rotate-on-AEOI: serving IR1 makes IR1 lowest
        AEOI = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h80);
        IR = 8'h02;
        tick(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("aeoi_ack1_ISR", ISR_o, 8'h02);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("aeoi_ack2_ISR", ISR_o, 8'h00);
        checkOutput("aeoi_vec_valid", {7'd0, vec_valid}, 8'h01);
        checkOutput("aeoi_VEC", {5'd0, INT_VEC}, 8'h01);
        IR = 8'h00;
        tick();
        IR = 8'h09;
        tick(); tick();
        checkOutput("aeoi_rot_INT", {7'd0, INT}, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("aeoi_rot_VEC", {5'd0, INT_VEC}, 8'h03);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("aeoi_ir0_VEC", {5'd0, INT_VEC}, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("aeoi_ir0_ISR", ISR_o, 8'h00);
        AEOI = 1'b0;
        IR = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC7);

        // Level-triggered mode follows IR directly
        LTIM = 1'b1;
        IR = 8'h04;
        tick();
        checkOutput("level_IRR_set", IRR_o, 8'h04);
        IR = 8'h00;
        tick();
        checkOutput("level_IRR_clr", IRR_o, 8'h00);
        LTIM = 1'b0;
        tick();

        // Special fully nested: same level re-request while in service
        IR = 8'h08;
        tick(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        IR = 8'h00;
        tick();
        IR = 8'h08;
        tick(); tick();
        checkOutput("sfnm_off_INT", {7'd0, INT}, 8'h00);
        SFNM = 1'b1;
        tick();
        checkOutput("sfnm_on_INT", {7'd0, INT}, 8'h01);
        SFNM = 1'b0;
        IR = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        tick();
        checkOutput("sfnm_cleanup_ISR", ISR_o, 8'h00);

`ifdef PIC_SPECIAL_MASK_EN
        // Masked in-service IR2 blocks IR6 until special mask mode is on
        IR = 8'h04;
        tick(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        IR = 8'h00;
        IMR = 8'h04;
        tick();
        IR = 8'h40;
        tick(); tick();
        checkOutput("smm_off_INT", {7'd0, INT}, 8'h00);
        smm_wr = 1'b1; smm = 2'b11;
        tick();
        smm_wr = 1'b0;
        tick();
        checkOutput("smm_on_INT", {7'd0, INT}, 8'h01);
        smm_wr = 1'b1; smm = 2'b10;
        tick();
        smm_wr = 1'b0;
        IR = 8'h00;
        IMR = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        tick();
        checkOutput("smm_cleanup_ISR", ISR_o, 8'h00);
`endif

        // Fully masked request: spurious IR7, then reset mid-acknowledge
        IMR = 8'hFF;
        IR = 8'h10;
        tick(); tick();
        checkOutput("masked_INT", {7'd0, INT}, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("spurious_VEC", {5'd0, INT_VEC}, 8'h07);
        checkOutput("spurious_ISR", ISR_o, 8'h00);
        checkOutput("spurious_IRR", IRR_o, 8'h10);
        IR = 8'h00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midack_reset_VEC", {5'd0, INT_VEC}, 8'h00);
        checkOutput("midack_reset_IRR", IRR_o, 8'h00);
        checkOutput("midack_reset_INT", {7'd0, INT}, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("idle_ack2_vec_valid", {7'd0, vec_valid}, 8'h00);
        checkOutput("idle_ack2_ISR", ISR_o, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
